// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch stage, the program ROM and the CPU decoder.
// The fetch stage is the master. The ROM and the decoder sit on the slave side.
interface instr_fetch_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] ROM_ADDR;
    logic [DATA_WIDTH-1:0] ROM_DATA;
    logic [DATA_WIDTH-1:0] INSTR_DATA;
    logic [ADDR_WIDTH-1:0] INSTR_ADDR;
    logic                  INSTR_VALID;
    logic                  INSTR_READY;
    logic                  JUMP_EN;
    logic [ADDR_WIDTH-1:0] JUMP_ADDR;

    modport master (
        output ROM_ADDR, INSTR_DATA, INSTR_ADDR, INSTR_VALID,
        input  ROM_DATA, INSTR_READY, JUMP_EN, JUMP_ADDR
    );

    modport slave (
        input  ROM_ADDR, INSTR_DATA, INSTR_ADDR, INSTR_VALID,
        output ROM_DATA, INSTR_READY, JUMP_EN, JUMP_ADDR
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction prefetch stage: drives the ROM address, absorbs its one-cycle read latency,
// and buffers fetched bytes in a small FIFO for the decoder. A jump redirects fetch and flushes the FIFO.
module instr_fetch #(
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    DEPTH        = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input logic           CLK,
    input logic           RESET,
    instr_fetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] fp;
    logic [ADDR_WIDTH-1:0] if_a;
    logic                  if_v;
    logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW:0]           occupancy;
    logic                  issue;
    logic                  push;
    logic                  pop;

    // The in-flight byte reserves a FIFO slot. This makes overflow impossible without looking at pop.
    always_comb begin
        occupancy = {1'b0, count} + {{CW{1'b0}}, if_v};
        issue     = !bus.JUMP_EN && (occupancy < (CW + 1)'(DEPTH));
        push      = if_v && !bus.JUMP_EN;
        pop       = (count != '0) && bus.INSTR_READY;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fp     <= RESET_VECTOR;
            if_v   <= 1'b0;
            if_a   <= '0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.JUMP_EN) begin
            fp     <= bus.JUMP_ADDR;
            if_v   <= 1'b0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if_v <= issue;
            if (issue) begin
                if_a <= fp;
                fp   <= fp + ADDR_WIDTH'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left unreset. Only the pointers and count define its contents.
    always_ff @(posedge CLK) begin
        if (push && !RESET) begin
            fifo_data[wr_ptr] <= bus.ROM_DATA;
            fifo_addr[wr_ptr] <= if_a;
        end
    end

    assign bus.ROM_ADDR    = fp;
    assign bus.INSTR_DATA  = fifo_data[rd_ptr];
    assign bus.INSTR_ADDR  = fifo_addr[rd_ptr];
    assign bus.INSTR_VALID = (count != '0);
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. A ROM model feeds the DUT, and a scoreboard queue holds the bytes the decoder should see.
// A negedge monitor pops the queue and compares against every completed handshake.
module tb_instr_fetch;
    logic clk;
    logic reset;
    int   checks_total;
    int   checks_passed;

    logic [7:0]  rom_mem [256];
    logic [15:0] exp_q [$];

    instr_fetch_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

    instr_fetch #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (8),
        .DEPTH       (4),
        .RESET_VECTOR(8'h00)
    ) dut (
        .CLK  (clk),
        .RESET(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) bus.ROM_DATA <= rom_mem[bus.ROM_ADDR];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic ready, input logic jump_en, input logic [7:0] jump_addr);
        reset           = rst;
        bus.INSTR_READY = ready;
        bus.JUMP_EN     = jump_en;
        bus.JUMP_ADDR   = jump_addr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expectByte(input logic [7:0] addr);
        logic [7:0] data;
        data = addr ^ 8'hA5;
        exp_q.push_back({addr, data});
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        step();
        step();
        @(negedge clk);
        checkOutput("resetRomAddr", {24'd0, bus.ROM_ADDR}, 32'h00);
        checkOutput("resetValid", {31'd0, bus.INSTR_VALID}, 32'h0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic drainFifo(input int max_cycles, output int used);
        bus.INSTR_READY = 1'b1;
        used = 0;
        while (exp_q.size() != 0 && used < max_cycles) begin
            step();
            used++;
        end
        bus.INSTR_READY = 1'b0;
        checkOutput("drainDone", exp_q.size(), 32'd0);
    endtask

    // The monitor compares every completed handshake against the head of the scoreboard.
    always @(negedge clk) begin
        logic [15:0] e;
        if (!reset && bus.INSTR_VALID && bus.INSTR_READY) begin
            if (exp_q.size() == 0) begin
                checks_total++;
                $display("[TB] FAIL unexpectedByte: got addr %h data %h, expected no byte",
                         bus.INSTR_ADDR, bus.INSTR_DATA);
            end else begin
                e = exp_q.pop_front();
                checkOutput("instrAddr", {24'd0, bus.INSTR_ADDR}, {24'd0, e[15:8]});
                checkOutput("instrData", {24'd0, bus.INSTR_DATA}, {24'd0, e[7:0]});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int used;
        checks_total  = 0;
        checks_passed = 0;
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i) ^ 8'hA5;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

        $display("[TB] startup streaming");
        doReset();
        for (int i = 0; i < 8; i++) expectByte(8'(i));
        bus.INSTR_READY = 1'b1;
        @(negedge clk);
        checkOutput("startCycle0Valid", {31'd0, bus.INSTR_VALID}, 32'h0);
        step();
        @(negedge clk);
        checkOutput("startCycle1Valid", {31'd0, bus.INSTR_VALID}, 32'h0);
        step();
        @(negedge clk);
        checkOutput("startCycle2Valid", {31'd0, bus.INSTR_VALID}, 32'h1);
        drainFifo(40, used);
        checkOutput("startNoGaps", used, 32'd8);

        $display("[TB] backpressure fill");
        doReset();
        for (int i = 0; i < 9; i++) step();
        @(negedge clk);
        checkOutput("fullRomAddr", {24'd0, bus.ROM_ADDR}, 32'h04);
        checkOutput("fullValid", {31'd0, bus.INSTR_VALID}, 32'h1);
        step();
        for (int i = 0; i < 8; i++) expectByte(8'(i));
        drainFifo(40, used);

        $display("[TB] address wrap");
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hFE);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("wrapRomAddr", {24'd0, bus.ROM_ADDR}, 32'hFE);
        expectByte(8'hFE);
        expectByte(8'hFF);
        expectByte(8'h00);
        expectByte(8'h01);
        drainFifo(40, used);

        $display("[TB] jump with full pipeline");
        doReset();
        for (int i = 0; i < 4; i++) step();
        expectByte(8'h00);
        expectByte(8'h40);
        expectByte(8'h41);
        expectByte(8'h42);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h40);
        step();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("jumpT1Valid", {31'd0, bus.INSTR_VALID}, 32'h0);
        checkOutput("jumpT1RomAddr", {24'd0, bus.ROM_ADDR}, 32'h40);
        step();
        @(negedge clk);
        checkOutput("jumpT2Valid", {31'd0, bus.INSTR_VALID}, 32'h0);
        step();
        @(negedge clk);
        checkOutput("jumpT3Valid", {31'd0, bus.INSTR_VALID}, 32'h1);
        checkOutput("jumpT3Addr", {24'd0, bus.INSTR_ADDR}, 32'h40);
        drainFifo(40, used);

        $display("[TB] back-to-back jumps");
        doReset();
        expectByte(8'h20);
        expectByte(8'h21);
        expectByte(8'h22);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h10);
        step();
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h20);
        step();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("b2bRomAddr", {24'd0, bus.ROM_ADDR}, 32'h20);
        step();
        @(negedge clk);
        checkOutput("b2bT2Valid", {31'd0, bus.INSTR_VALID}, 32'h0);
        step();
        @(negedge clk);
        checkOutput("b2bT3Valid", {31'd0, bus.INSTR_VALID}, 32'h1);
        drainFifo(40, used);

        $display("[TB] reset mid-stream");
        doReset();
        for (int i = 0; i < 3; i++) step();
        @(negedge clk);
        checkOutput("halfFullValid", {31'd0, bus.INSTR_VALID}, 32'h1);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        step();
        expectByte(8'h00);
        expectByte(8'h01);
        expectByte(8'h02);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("rstCycle0Valid", {31'd0, bus.INSTR_VALID}, 32'h0);
        checkOutput("rstCycle0RomAddr", {24'd0, bus.ROM_ADDR}, 32'h00);
        step();
        @(negedge clk);
        checkOutput("rstCycle1Valid", {31'd0, bus.INSTR_VALID}, 32'h0);
        step();
        @(negedge clk);
        checkOutput("rstCycle2Valid", {31'd0, bus.INSTR_VALID}, 32'h1);
        checkOutput("rstCycle2Addr", {24'd0, bus.INSTR_ADDR}, 32'h00);
        drainFifo(40, used);

        step();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch and prefetch stage sitting directly upstream of the program ROM. It drives the ROM address bus, absorbs the ROM's one-cycle synchronous read latency, and buffers the fetched bytes in a small FIFO. It presents them to the CPU decoder one byte per cycle over a valid/ready handshake, with a jump input that redirects fetch and flushes stale bytes.

## Interface
- ADDR_WIDTH, 8, ROM address width; also the program counter width.
- DATA_WIDTH, 8, ROM/instruction byte width.
- DEPTH, 4, prefetch FIFO entries; power of two, ≥ 2.
- RESET_VECTOR, 8'h00, first fetch address after reset.
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- ROM_ADDR  out  ADDR_WIDTH  address to ROM; equals fetch pointer register.
- ROM_DATA  in  DATA_WIDTH  ROM output; holds mem[address presented in previous cycle].
- INSTR_DATA  out  DATA_WIDTH  FIFO head byte.
- INSTR_ADDR  out  ADDR_WIDTH  ROM address the head byte was fetched from.
- INSTR_VALID  out  1  FIFO non-empty.
- INSTR_READY  in  1  decoder accepts head byte this cycle.
- JUMP_EN  in  1  one-cycle redirect request.
- JUMP_ADDR  in  ADDR_WIDTH  redirect target, sampled when JUMP_EN=1.

## Operation
- State: fetch pointer FP, in-flight flag IF_V with tag IF_A, FIFO (data and address per entry), and occupancy COUNT (0..DEPTH).
- Issue condition, evaluated on start-of-cycle values: !RESET && !JUMP_EN && (COUNT + IF_V) < DEPTH. A simultaneous pop earns no credit.
- On issue, the ROM samples ROM_ADDR=FP this edge. Then IF_V←1, IF_A←FP, FP←FP+1, wrapping 2^ADDR_WIDTH-1 → 0.
- With no issue, IF_V←0 and FP holds.
- Capture: when IF_V=1 and there is no JUMP_EN, push {ROM_DATA, IF_A} into the FIFO at this edge.
- Pop: INSTR_VALID && INSTR_READY removes the head. Push and pop in the same cycle leave COUNT unchanged.
- Overflow is structurally impossible; the credit rule guarantees COUNT ≤ DEPTH.
- INSTR_READY while INSTR_VALID=0 has no effect.
- JUMP_EN=1 in cycle t:
  - A pop handshake in cycle t completes; the byte counts as consumed.
  - The FIFO is flushed, COUNT←0.
  - The in-flight byte is discarded: no push in t, and IF_V←0.
  - FP←JUMP_ADDR; no issue in t.
- JUMP_EN takes priority over every other event except RESET.
- A JUMP_EN held for multiple cycles re-flushes each cycle, and fetch resumes the cycle after its last assertion.
- RESET (priority over all): FP←RESET_VECTOR, IF_V←0, COUNT←0, FIFO pointers←0. FIFO storage is not cleared.
- RESET mid-operation discards everything in flight and buffered, including any byte arriving on ROM_DATA that cycle.

## Timing
- Reset values: ROM_ADDR=RESET_VECTOR, INSTR_VALID=0. INSTR_DATA and INSTR_ADDR are don't-care while INSTR_VALID=0.
- Startup, with cycle 0 the first cycle RESET=0:
  - cycle 0: issue RESET_VECTOR.
  - cycle 1: ROM_DATA valid, captured at end of cycle.
  - cycle 2: INSTR_VALID=1, INSTR_DATA=mem[RESET_VECTOR].
- Fetch-to-output latency is 2 cycles.
- Jump at cycle t:
  - t: INSTR_VALID may still be 1; the pop completes if READY.
  - t+1: INSTR_VALID=0, ROM_ADDR=JUMP_ADDR, issue.
  - t+3: INSTR_VALID=1, INSTR_DATA=mem[JUMP_ADDR], INSTR_ADDR=JUMP_ADDR.
- Jump penalty is 3 cycles.
- With READY held high, sustained throughput is 1 byte/cycle after the 2-cycle fill.
- With READY low, the FIFO fills to DEPTH. Issue then stops, and ROM_ADDR holds the next unfetched address.
- Outputs are register-driven: ROM_ADDR from FP, INSTR_* from the FIFO head. Only INSTR_READY and JUMP_EN feed same-cycle logic.

## Test plan
- Reset release with ROM preloaded mem[n]=n^8'hA5 and READY=1 -> INSTR_VALID rises in cycle 2; the bench sees bytes 8'hA5, 8'hA4, 8'hA7… with INSTR_ADDR 0, 1, 2…, one per cycle and no gaps.
- READY=0 for 10 cycles after reset -> COUNT saturates at 4, ROM_ADDR stops at 8'h04, no byte is lost or duplicated. Then READY=1 -> bytes 0..7 arrive in order.
- Wrap-around with JUMP_ADDR=8'hFE -> output addresses FE, FF, 00, 01 with matching data.
- JUMP_EN with JUMP_ADDR=8'h40 while FIFO holds 3 bytes, one read is in flight, and READY=1 -> the head byte is consumed in t; no stale byte ever appears; first post-jump output is mem[8'h40] at t+3.
- Back-to-back JUMP_EN to 8'h10 then 8'h20 -> only bytes from 8'h20 onward appear, the first at 3 cycles after the second jump.
- RESET asserted for one cycle mid-stream with the FIFO half full -> INSTR_VALID=0 the next cycle; refetch starts at RESET_VECTOR with the same 2-cycle latency.
